// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I funct3 codes,
// FSM state encoding and the decoded access size.
package riscv_mem_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_t;

    // Loads and stores have different legal funct3 sets; anything else is SZ_BAD.
    function automatic size_t decode_size(input logic we, input logic [2:0] funct3);
        size_t sz;
        sz = SZ_BAD;
        if (we) begin
            case (funct3)
                FUNCT3_SB: sz = SZ_BYTE;
                FUNCT3_SH: sz = SZ_HALF;
                FUNCT3_SW: sz = SZ_WORD;
                default:   sz = SZ_BAD;
            endcase
        end else begin
            case (funct3)
                FUNCT3_LB, FUNCT3_LBU: sz = SZ_BYTE;
                FUNCT3_LH, FUNCT3_LHU: sz = SZ_HALF;
                FUNCT3_LW:             sz = SZ_WORD;
                default:               sz = SZ_BAD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and replicated store data,
// load lane extraction with sign/zero extension, size and alignment checks.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    output logic        o_illegal,
    output logic [31:0] o_rdata
);

    size_t       w_size;
    logic        w_unsigned;
    logic [31:0] w_shift;

    assign w_size     = decode_size(i_we, i_funct3);
    assign w_unsigned = i_funct3[2];
    assign w_shift    = i_rword >> {i_addr_lo, 3'b000};

    // Lane selection and extension for each decoded size
    always_comb begin
        o_byte_en  = 4'b0000;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        o_rdata    = 32'h0;
        case (w_size)
            SZ_BYTE: begin
                o_byte_en = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_wdata[7:0]}};
                o_rdata   = {{24{~w_unsigned & w_shift[7]}}, w_shift[7:0]};
            end
            SZ_HALF: begin
                o_byte_en  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_addr_lo[0];
                o_rdata    = {{16{~w_unsigned & w_shift[15]}}, w_shift[15:0]};
            end
            SZ_WORD: begin
                o_byte_en  = 4'b1111;
                o_misalign = (i_addr_lo != 2'b00);
                o_rdata    = w_shift;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready request/response handshake
// with programmable wait states. The array is treated as a synchronous-read
// word SRAM without byte masks, so ACCESS spends one cycle reading the word
// and a second merging/committing it and registering the aligned result.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// WAIT   | counting programmed wait states down to 0
// ACCESS | phase 0: array read; phase 1: store commit / load result capture
// RESP   | rsp_valid held with stable data until rsp_ready
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_rmw_phase;
    logic        r_we;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic [31:0] r_rword;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic [31:0]   w_index;
    logic          w_oor;
    logic [AW-1:0] w_widx;
    logic [3:0]    w_byte_en;
    logic [31:0]   w_wdata_lane;
    logic          w_misalign;
    logic          w_illegal;
    logic [31:0]   w_rdata_ext;
    logic          w_err;
    logic          w_commit;
    logic [31:0]   w_merged;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_index  = (r_addr - BASE_ADDR) >> 2;
    assign w_oor    = (w_index >= 32'(DEPTH_WORDS));
    assign w_widx   = w_index[AW-1:0];
    assign w_err    = w_oor | w_misalign | w_illegal;
    assign w_commit = (r_state == ACCESS) && r_rmw_phase;

    dmem_lane_align u_align (
        .i_we       (r_we),
        .i_funct3   (r_funct3),
        .i_addr_lo  (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_rword    (r_rword),
        .o_byte_en  (w_byte_en),
        .o_wdata    (w_wdata_lane),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal),
        .o_rdata    (w_rdata_ext)
    );

    // Byte-wise merge of new store data over the previously read word
    always_comb begin
        w_merged = r_rword;
        for (int i = 0; i < 4; i++) begin
            if (w_byte_en[i]) w_merged[8*i +: 8] = w_wdata_lane[8*i +: 8];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (r_cnt == 4'd0) w_next = ACCESS;
            ACCESS:  if (r_rmw_phase) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready = (r_state == IDLE);
        rsp_valid = (r_state == RESP);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end

    // Request capture, wait counter, read word and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_rmw_phase <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_funct3    <= 3'b000;
            r_wdata     <= 32'h0;
            r_rword     <= 32'h0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we        <= req_we;
                r_addr      <= req_addr;
                r_funct3    <= req_funct3;
                r_wdata     <= req_wdata;
                r_cnt       <= WAIT_LOAD;
                r_rmw_phase <= 1'b0;
            end
            if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (r_state == ACCESS) begin
                if (!r_rmw_phase) begin
                    r_rword     <= r_mem[w_widx];
                    r_rmw_phase <= 1'b1;
                end else begin
                    r_rdata <= (w_err || r_we) ? 32'h0 : w_rdata_ext;
                    r_err   <= w_err;
                end
            end
        end
    end

    // Array write; contents deliberately have no reset
    always_ff @(posedge clk) begin
        if (w_commit && r_we && !w_err) r_mem[w_widx] <= w_merged;
    end

endmodule
